// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between fifo_stream_reader, its source FIFO and the downstream sink.
// The master modport is the reader; the slave modport is the FIFO/sink environment.
interface fifo_stream_reader_if #(
    parameter int unsigned DWIDTH     = 64,
    parameter int unsigned RD_LATENCY = 1
);
    localparam int unsigned OCC_W = $clog2(RD_LATENCY + 3);

    logic              fifo_empty_i;
    logic [DWIDTH-1:0] fifo_q_i;
    logic              fifo_rdreq_o;
    logic              flush_i;
    logic [DWIDTH-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic [OCC_W-1:0]  occupancy_o;

    modport master (
        input  fifo_empty_i, fifo_q_i, flush_i, ready_i,
        output fifo_rdreq_o, data_o, valid_o, occupancy_o
    );

    modport slave (
        output fifo_empty_i, fifo_q_i, flush_i, ready_i,
        input  fifo_rdreq_o, data_o, valid_o, occupancy_o
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: issues credit-limited rdreq, captures q after the FIFO's
// fixed read latency into a small skid buffer and presents it as a valid/ready stream.
module fifo_stream_reader #(
    parameter int unsigned DWIDTH     = 64,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fifo_stream_reader_if.master bus
);
    localparam int unsigned BUF_DEPTH = RD_LATENCY + 2;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W     = OCC_W + 1;

    logic [RD_LATENCY-1:0] inflight_sr;
    logic [DWIDTH-1:0]     buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occupancy;
    logic [SUM_W-1:0]      credit_used;
    logic                  rdreq;
    logic                  capture;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts both buffered and in-flight words, so a capture always has room.
    always_comb begin
        credit_used = SUM_W'($countones(inflight_sr)) + SUM_W'(occupancy);
        rdreq       = !rst_i && !bus.flush_i && !bus.fifo_empty_i
                      && (credit_used < SUM_W'(BUF_DEPTH));
    end

    assign capture = inflight_sr[RD_LATENCY-1] && !bus.flush_i;
    assign pop     = (occupancy != '0) && bus.ready_i && !bus.flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_sr <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (bus.flush_i) begin
            inflight_sr <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
        end else begin
            inflight_sr <= (inflight_sr << 1) | RD_LATENCY'(rdreq);
            if (capture) begin
                buf_mem[wr_ptr] <= bus.fifo_q_i;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (capture && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (!capture && pop) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    assign bus.fifo_rdreq_o = rdreq;
    assign bus.valid_o      = (occupancy != '0);
    assign bus.data_o       = buf_mem[rd_ptr];
    assign bus.occupancy_o  = occupancy;

    a_occ_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        occupancy <= OCC_W'(BUF_DEPTH));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && occupancy == '0));
    a_no_rdreq_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rdreq && bus.fifo_empty_i));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader at RD_LATENCY 1, 2 and 3 with a FIFO model per instance
// and a per-instance word scoreboard checked on every stream transfer.
module tb_fifo_stream_reader;
    localparam int unsigned DW    = 64;
    localparam int unsigned NI    = 3;
    localparam int unsigned MEMSZ = 1024;
    localparam logic [DW-1:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        logic ready;
        logic rdreq;
        logic valid;
        int   occ;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          model_clr = 1'b1;
    logic          ready   [NI];
    logic          flush   [NI];
    logic          valid_w [NI];
    logic          rdreq_w [NI];
    logic          empty_w [NI];
    logic [2:0]    occ_w   [NI];
    logic [DW-1:0] data_w  [NI];
    int unsigned   rd_w    [NI];
    int unsigned   n       [NI];
    int unsigned   xfer    [NI];
    logic [DW-1:0] mem     [NI][MEMSZ];
    logic [DW-1:0] sb      [NI][$];
    int            checks = 0;
    int            errors = 0;

    for (genvar k = 0; k < NI; k++) begin : g_lat
        localparam int unsigned L = k + 1;
        logic [DW-1:0] pipe [L];
        int unsigned   rd_idx = 0;

        fifo_stream_reader_if #(.DWIDTH(DW), .RD_LATENCY(L)) bus ();
        fifo_stream_reader #(.DWIDTH(DW), .RD_LATENCY(L)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );

        assign empty_w[k]       = (rd_idx >= n[k]);
        assign bus.fifo_empty_i = empty_w[k];
        assign bus.fifo_q_i     = pipe[L-1];
        assign bus.ready_i      = ready[k];
        assign bus.flush_i      = flush[k];
        assign valid_w[k]       = bus.valid_o;
        assign rdreq_w[k]       = bus.fifo_rdreq_o;
        assign occ_w[k]         = 3'(bus.occupancy_o);
        assign data_w[k]        = bus.data_o;
        assign rd_w[k]          = rd_idx;

        // FIFO model: word popped on the rdreq edge, visible L clocks after rdreq.
        always @(posedge clk) begin
            if (model_clr) rd_idx <= 0;
            else if (rdreq_w[k]) rd_idx <= rd_idx + 1;
            pipe[0] <= rdreq_w[k] ? mem[k][rd_idx % MEMSZ] : GARBAGE;
            for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
        end
    end

    // Scoreboard: every transfer must match the oldest word not yet delivered.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            for (int k = 0; k < int'(NI); k++) begin
                if (model_clr) begin
                    sb[k].delete();
                    xfer[k] = 0;
                end else if (!rst) begin
                    checks++;
                    if (rdreq_w[k] && empty_w[k]) begin
                        errors++;
                        $display("FAIL rdreq_when_empty lat=%0d got rdreq=1 need rdreq=0", k + 1);
                    end
                    if (valid_w[k] && ready[k] && !flush[k]) begin
                        checks++;
                        xfer[k]++;
                        if (sb[k].size() == 0) begin
                            errors++;
                            $display("FAIL extra_word lat=%0d got %0h need no transfer", k + 1, data_w[k]);
                        end else begin
                            exp = sb[k].pop_front();
                            if (data_w[k] !== exp) begin
                                errors++;
                                $display("FAIL stream_data lat=%0d got %0h need %0h", k + 1, data_w[k], exp);
                            end
                        end
                    end
                    if (flush[k]) begin
                        while (sb[k].size() > int'(n[k] - rd_w[k])) void'(sb[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d need %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        rst       = 1'b1;
        model_clr = 1'b1;
        for (int k = 0; k < int'(NI); k++) begin
            ready[k] = 1'b0;
            flush[k] = 1'b0;
            n[k]     = 0;
        end
        step();
        step();
        model_clr = 1'b0;
    endtask

    task automatic preload(input int k, input int count, input logic [DW-1:0] base, input bit rnd);
        logic [DW-1:0] v;
        for (int i = 0; i < count; i++) begin
            v = rnd ? {$urandom(), $urandom()} : base + DW'(i);
            mem[k][i] = v;
            sb[k].push_back(v);
        end
        n[k] = count;
    endtask

    task automatic drain(input int k, input int budget, input string name);
        int c;
        ready[k] = 1'b1;
        c = 0;
        while (sb[k].size() != 0 && c < budget) begin
            step();
            c++;
        end
        @(negedge clk);
        chk({name, "_drained"}, sb[k].size(), 0);
    endtask

    vec_t tbl [18];
    int   lat;
    int   run;
    int   c;
    bit   all_done;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2};
        for (int i = 6; i <= 13; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 3};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 3};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 2};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1};

        // Reset with a non-empty FIFO, then release into the backpressure table.
        clear_all();
        preload(0, 40, 64'h1000, 1'b0);
        ready[0] = 1'b1;
        @(negedge clk);
        chk("reset_rdreq", int'(rdreq_w[0]), 0);
        chk("reset_valid", int'(valid_w[0]), 0);
        chk("reset_occ", int'(occ_w[0]), 0);
        chk("reset_data", longint'(data_w[0]), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            ready[0] = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_rdreq", i), int'(rdreq_w[0]), int'(tbl[i].rdreq));
            chk($sformatf("tbl%0d_valid", i), int'(valid_w[0]), int'(tbl[i].valid));
            chk($sformatf("tbl%0d_occ", i), int'(occ_w[0]), tbl[i].occ);
            step();
        end
        drain(0, 200, "bp");
        chk("bp_xfer", xfer[0], 40);

        // Full-rate stream of 0..99 at latency 1.
        clear_all();
        preload(0, 100, 64'h0, 1'b0);
        ready[0] = 1'b1;
        step();
        rst = 1'b0;
        lat = -1;
        for (int cy = 0; cy < 10; cy++) begin
            @(negedge clk);
            if (valid_w[0]) begin
                lat = cy;
                break;
            end
            step();
        end
        run = 0;
        while (valid_w[0] && run < 110) begin
            run++;
            step();
            @(negedge clk);
        end
        chk("stream_latency", lat, 2);
        chk("stream_run", run, 100);
        chk("stream_xfer", xfer[0], 100);
        chk("stream_left", sb[0].size(), 0);

        // Single-word FIFO: one rdreq, one transfer, then idle.
        clear_all();
        preload(0, 1, 64'hA5A5_0001, 1'b0);
        ready[0] = 1'b1;
        step();
        rst = 1'b0;
        for (int cy = 0; cy < 10; cy++) step();
        @(negedge clk);
        chk("one_rdreqs", rd_w[0], 1);
        chk("one_xfer", xfer[0], 1);
        chk("one_valid_after", int'(valid_w[0]), 0);
        chk("one_rdreq_after", int'(rdreq_w[0]), 0);

        // Flush at latency 2 with three buffered words and one in flight.
        clear_all();
        preload(1, 20, 64'h2000, 1'b0);
        step();
        rst = 1'b0;
        c = 0;
        while (occ_w[1] != 3'd2 && c < 20) begin
            step();
            c++;
        end
        chk("flush_reach_occ2", int'(occ_w[1]), 2);
        step();
        flush[1] = 1'b1;
        ready[1] = 1'b1;
        @(negedge clk);
        chk("flush_occ_before", int'(occ_w[1]), 3);
        chk("flush_inflight", longint'(rd_w[1]) - longint'(occ_w[1]), 1);
        chk("flush_rdreq", int'(rdreq_w[1]), 0);
        step();
        flush[1] = 1'b0;
        @(negedge clk);
        chk("flush_valid_after", int'(valid_w[1]), 0);
        chk("flush_occ_after", int'(occ_w[1]), 0);
        drain(1, 200, "flush");
        chk("flush_xfer", xfer[1], 16);

        // Random backpressure, 1000 random words on every latency.
        clear_all();
        for (int k = 0; k < int'(NI); k++) preload(k, 1000, '0, 1'b1);
        step();
        rst = 1'b0;
        c = 0;
        all_done = 1'b0;
        while (!all_done && c < 6000) begin
            for (int k = 0; k < int'(NI); k++) ready[k] = 1'($urandom_range(0, 1));
            step();
            c++;
            all_done = (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
        end
        @(negedge clk);
        for (int k = 0; k < int'(NI); k++) begin
            chk($sformatf("rand_lat%0d_xfer", k + 1), xfer[k], 1000);
            chk($sformatf("rand_lat%0d_left", k + 1), sb[k].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
